// File: rtl/not_gate_bist_pkg.sv
// Shared types and constants for the gate-bank self-test.
// State encodings are fixed so the debug port view stays stable.
package not_gate_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [7:0] ERR_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/not_gate_bist_settle_timer.sv
// Loadable down-counter that times the settle window.
// Counts down to zero and parks there until reloaded.
module bist_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/not_gate_bist.sv
// Exhaustive-vector self-test for a bank of WIDTH gates.
// Sweeps every input, compares after a settle window, counts misses.
module not_gate_bist
  import not_gate_bist_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter bit INVERT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] first_fail_vec
);

  localparam logic [WIDTH:0] LAST =
    {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE =
    (WIDTH+1)'(1);
  localparam logic [3:0] LOAD_VAL =
    4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   vec_q, vec_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] ffv_q, ffv_d;
  logic [7:0]       err_q, err_d;
  logic             pass_q, pass_d;
  logic             tmr_load;
  logic             tmr_zero;
  logic [WIDTH-1:0] exp_y;
  logic             miss;

  bist_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .zero     (tmr_zero)
  );

  assign exp_y = INVERT ? ~vec_q[WIDTH-1:0]
                        :  vec_q[WIDTH-1:0];
  // X/Z on the bank output must count as a miss
  assign miss  = (dut_y !== exp_y);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    a_d      = a_q;
    ffv_d    = ffv_q;
    err_d    = err_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 8'd0;
          ffv_d   = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        a_d      = vec_q[WIDTH-1:0];
        tmr_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (tmr_zero) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (miss) begin
          err_d = sat_inc(err_q);
          if (err_q == 8'd0)
            ffv_d = vec_q[WIDTH-1:0];
        end
        if (vec_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + ONE;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        pass_d  = (err_q == 8'd0);
        a_d     = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      a_q     <= '0;
      ffv_q   <= '0;
      err_q   <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      ffv_q   <= ffv_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_a          = a_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_not_gate_bist.sv
// Bench: three BIST instances (1/4/8 lanes) against modelled gate banks.
// Expected run results are queued at start and popped at done.
module tb_not_gate_bist;

  localparam int WD[3] = '{1, 4, 8};
  localparam int SD[3] = '{2, 1, 1};

  typedef struct {
    int         id;
    logic [7:0] err;
    logic [7:0] ffv;
    bit         pass;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start;
  logic [2:0] mode;
  logic       a0, y0, f0;
  logic [3:0] a4, y4, f4;
  logic [7:0] a8, y8, f8;
  logic [2:0] busy, done, pass;
  logic [7:0] err0, err1, err2;
  logic [7:0] b0, b1, b2;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Bank models: mode 0 ideal inverters, mode 1 the faulty bank
  function automatic logic [7:0] bank(
    int id, bit m, logic [7:0] a
  );
    case (id)
      0:       return m ? 8'h00 : (~a & 8'h01);
      1:       return m ? ((~a | 8'h04) & 8'h0F)
                        : (~a & 8'h0F);
      default: return m ? a : ~a;
    endcase
  endfunction

  assign b0 = bank(0, mode[0], {7'b0, a0});
  assign b1 = bank(1, mode[1], {4'b0, a4});
  assign b2 = bank(2, mode[2], a8);
  assign y0 = b0[0];
  assign y4 = b1[3:0];
  assign y8 = b2;

  not_gate_bist #(.WIDTH(1), .SETTLE(2), .INVERT(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .dut_a(a0), .dut_y(y0), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]),
    .err_count(err0), .first_fail_vec(f0)
  );

  not_gate_bist #(.WIDTH(4), .SETTLE(1), .INVERT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .dut_a(a4), .dut_y(y4), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]),
    .err_count(err1), .first_fail_vec(f4)
  );

  not_gate_bist #(.WIDTH(8), .SETTLE(1), .INVERT(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]),
    .dut_a(a8), .dut_y(y8), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]),
    .err_count(err2), .first_fail_vec(f8)
  );

  function automatic logic [7:0] get_a(int id);
    case (id)
      0:       return {7'b0, a0};
      1:       return {4'b0, a4};
      default: return a8;
    endcase
  endfunction

  function automatic logic [7:0] get_ffv(int id);
    case (id)
      0:       return {7'b0, f0};
      1:       return {4'b0, f4};
      default: return f8;
    endcase
  endfunction

  function automatic logic [7:0] get_err(int id);
    case (id)
      0:       return err0;
      1:       return err1;
      default: return err2;
    endcase
  endfunction

  task automatic chk(
    string tag, logic [31:0] got, logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int id, bit m);
    exp_t       e;
    int         n;
    logic [7:0] msk, y, x;
    n     = 1 << WD[id];
    msk   = 8'((1 << WD[id]) - 1);
    e.id  = id;
    e.err = 8'd0;
    e.ffv = 8'd0;
    for (int v = 0; v < n; v++) begin
      y = bank(id, m, 8'(v));
      x = ~8'(v) & msk;
      if (y != x) begin
        if (e.err == 8'd0) e.ffv = 8'(v);
        if (e.err != 8'd255) e.err = e.err + 8'd1;
      end
    end
    e.pass = (e.err == 8'd0);
    e.lat  = n * (SD[id] + 2);
    return e;
  endfunction

  task automatic run(int id, bit m, int restart_at);
    exp_t e;
    int   c;
    int   k;
    int   per;
    int   nd;
    bit   got;
    mode[id] = m;
    sb.push_back(model(id, m));
    per = SD[id] + 2;
    @(negedge clk);
    start[id] = 1'b1;
    @(posedge clk);
    #1 start[id] = 1'b0;
    chk($sformatf("busy_on%0d", id), busy[id], 1);
    c   = 0;
    got = 0;
    while (c <= 300 * per) begin
      @(negedge clk);
      start[id] = (c == restart_at);
      if (c >= 1 && (c - 1) % per == 0) begin
        k = (c - 1) / per;
        chk($sformatf("dut_a%0d", id),
            get_a(id), k);
      end
      if (done[id]) begin
        got = 1;
        break;
      end
      @(posedge clk);
      c++;
    end
    start[id] = 1'b0;
    e = sb.pop_front();
    chk($sformatf("timeout%0d", id), got, 1);
    if (got) begin
      chk($sformatf("lat%0d", id), c, e.lat);
      chk($sformatf("err%0d", id),
          get_err(id), e.err);
      chk($sformatf("ffv%0d", id),
          get_ffv(id), e.ffv);
      @(posedge clk);
      #1;
      chk($sformatf("pass%0d", id), pass[id], e.pass);
      chk($sformatf("busy_off%0d", id), busy[id], 0);
      nd = 0;
      repeat (6) begin
        @(negedge clk);
        if (done[id]) nd++;
      end
      chk($sformatf("extra_done%0d", id), nd, 0);
    end
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    start = '0;
    mode  = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_pass", pass[i], 0);
      chk("rst_err", get_err(i), 0);
      chk("rst_ffv", get_ffv(i), 0);
      chk("rst_a", get_a(i), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 1'b1, -1);
    run(0, 1'b0, -1);
    run(1, 1'b1, -1);
    run(1, 1'b0, 4);
    run(1, 1'b1, 5);
    run(2, 1'b1, -1);
    run(2, 1'b0, -1);

    // Reset while vector 1 is settling
    mode[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_err", err0, 1);
    chk("pre_rst_a", a0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", a0, 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_err", err0, 0);
    chk("mid_rst_ffv", f0, 0);
    chk("mid_rst_pass", pass[0], 0);
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    chk("rst_no_done", nd, 0);
    run(0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
